// File: rtl/jam_cost_arb.sv
// jam_cost_arb: two-port round-robin arbiter in front of the shared job
// assignment cost table. One read is granted per cycle. The table address is
// registered, and the cost comes back to the winning engine one cycle later.
// An engine may hold the grant with its lock bit for up to BURST_MAX
// consecutive grants while the other engine is waiting.
//
// Ports:
//   CLK, RST           clock, asynchronous active-high reset
//   req0/1, lock0/1    read request and lock-keep request from engine 0/1
//   w0,j0 / w1,j1      worker/job address from engine 0/1
//   gnt0/1             registered grant (address of that engine is on W/J)
//   rvalid0/1, rdata   registered cost return, qualified per engine
//   W, J               registered cost table address
//   Cost               cost table data for the current W/J
//   busy               registered, gnt0|gnt1
//   gcnt0/1, wcnt      grant and wait counters (only with JAM_COST_ARB_STATS_EN)
//
// Optional feature macro: JAM_COST_ARB_STATS_EN
module jam_cost_arb #(
  parameter int unsigned BURST_MAX = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req0,
  input  logic        req1,
  input  logic        lock0,
  input  logic        lock1,
  input  logic [2:0]  w0,
  input  logic [2:0]  j0,
  input  logic [2:0]  w1,
  input  logic [2:0]  j1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [6:0]  rdata,
  output logic [2:0]  W,
  output logic [2:0]  J,
  input  logic [6:0]  Cost,
  output logic        busy
`ifdef JAM_COST_ARB_STATS_EN
  ,
  output logic [15:0] gcnt0,
  output logic [15:0] gcnt1,
  output logic [15:0] wcnt
`endif
);

  localparam logic [3:0] BMAX = 4'(BURST_MAX);

  logic [1:0]      req, lock;
  logic [1:0][5:0] addr;

  assign req  = {req1, req0};
  assign lock = {lock1, lock0};
  assign addr = {{w1, j1}, {w0, j0}};

  logic [1:0] gnt_q, gnt_d;
  logic [1:0] rvalid_q, rvalid_d;
  logic [6:0] rdata_q, rdata_d;
  logic [2:0] w_q, w_d, j_q, j_d;
  logic       busy_q, busy_d;
  logic       owner_q, owner_d;
  logic       locked_q, locked_d;
  logic [3:0] burst_q, burst_d;
  logic       win;

  always_comb begin
    gnt_d    = '0;
    w_d      = w_q;
    j_d      = j_q;
    owner_d  = owner_q;
    locked_d = 1'b0;
    burst_d  = burst_q;
    win      = req[1];
    // Under contention the owner keeps the table only while its lock is live
    // and the burst budget is not spent; otherwise the grant rotates.
    if (&req)
      win = (locked_q && (burst_q < BMAX)) ? owner_q : ~owner_q;
    if (|req) begin
      gnt_d[win]   = 1'b1;
      {w_d, j_d}   = addr[win];
      locked_d     = lock[win];
      if (win == owner_q) begin
        burst_d = (burst_q == 4'd15) ? 4'd15 : burst_q + 4'd1;
      end else begin
        burst_d = 4'd1;
        owner_d = win;
      end
    end
    busy_d   = |gnt_d;
    // The table answers for last cycle's grant; rdata holds when idle.
    rvalid_d = gnt_q;
    rdata_d  = (|gnt_q) ? Cost : rdata_q;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      gnt_q    <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
      w_q      <= '0;
      j_q      <= '0;
      busy_q   <= 1'b0;
      owner_q  <= 1'b1;   // engine 0 wins the first contention
      locked_q <= 1'b0;
      burst_q  <= '0;
    end else begin
      gnt_q    <= gnt_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      w_q      <= w_d;
      j_q      <= j_d;
      busy_q   <= busy_d;
      owner_q  <= owner_d;
      locked_q <= locked_d;
      burst_q  <= burst_d;
    end
  end

  assign gnt0    = gnt_q[0];
  assign gnt1    = gnt_q[1];
  assign rvalid0 = rvalid_q[0];
  assign rvalid1 = rvalid_q[1];
  assign rdata   = rdata_q;
  assign W       = w_q;
  assign J       = j_q;
  assign busy    = busy_q;

`ifdef JAM_COST_ARB_STATS_EN
  logic [1:0][15:0] gcnt_q, gcnt_d;
  logic [15:0]      wcnt_q, wcnt_d;

  always_comb begin
    gcnt_d[0] = gcnt_q[0] + {15'd0, gnt_d[0]};
    gcnt_d[1] = gcnt_q[1] + {15'd0, gnt_d[1]};
    // At most one engine can be left waiting in a cycle.
    wcnt_d    = wcnt_q + {15'd0, |(req & ~gnt_d)};
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      gcnt_q <= '0;
      wcnt_q <= '0;
    end else begin
      gcnt_q <= gcnt_d;
      wcnt_q <= wcnt_d;
    end
  end

  assign gcnt0 = gcnt_q[0];
  assign gcnt1 = gcnt_q[1];
  assign wcnt  = wcnt_q;
`endif

endmodule

// File: tb/tb_jam_cost_arb.sv
// Bench for jam_cost_arb: scripted engines hold req/address until granted,
// a reference arbiter pushes expected grants into a queue as stimulus is
// driven, and the DUT's grants and cost returns are popped and compared.
module tb_jam_cost_arb;
  localparam int BM = 8;

  logic       CLK = 1'b0;
  logic       RST;
  logic       req0, req1, lock0, lock1;
  logic [2:0] w0, j0, w1, j1;
  logic       gnt0, gnt1, rvalid0, rvalid1, busy;
  logic [6:0] rdata, Cost;
  logic [2:0] W, J;
`ifdef JAM_COST_ARB_STATS_EN
  logic [15:0] gcnt0, gcnt1, wcnt;
`endif

  jam_cost_arb #(.BURST_MAX(BM)) dut (
    .CLK(CLK), .RST(RST),
    .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
    .w0(w0), .j0(j0), .w1(w1), .j1(j1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .W(W), .J(J), .Cost(Cost), .busy(busy)
`ifdef JAM_COST_ARB_STATS_EN
    , .gcnt0(gcnt0), .gcnt1(gcnt1), .wcnt(wcnt)
`endif
  );

  always #5 CLK = ~CLK;

  // Cost table: injective over the 8x8 space, Cost(2,5)=37.
  function automatic logic [6:0] cost_f(input logic [2:0] w, input logic [2:0] j);
    return 7'(int'(w) * 11 + int'(j) * 3);
  endfunction
  assign Cost = cost_f(W, J);

  typedef struct packed { logic [1:0] eng; logic [2:0] w; logic [2:0] j; } gexp_t;
  typedef struct packed { logic [1:0] eng; logic [6:0] d; } rexp_t;
  gexp_t gq[$];
  rexp_t rq[$];
  int    dut_log[$];

  int n_tests = 0;
  int n_fail  = 0;

  // reference arbiter state
  logic       m_owner, m_locked;
  logic [3:0] m_burst;
  logic [2:0] m_w, m_j;
  logic [6:0] m_rdata;

  // engine state
  int         rem0, rem1, mode0, mode1;
  logic [5:0] a0 = 6'd0, a1 = 6'd0;
  logic       lk0, lk1;

  int exp_lock[13] = '{0,0,0,0,0,0,0,0,1,0,0,1,1};
  int exp_idle[24];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic pick(input int mode);
    return (mode == 2) ? 1'($urandom_range(0, 1)) : 1'(mode);
  endfunction

  task automatic model_reset();
    m_owner = 1'b1; m_locked = 1'b0; m_burst = 4'd0;
    m_w = 3'd0; m_j = 3'd0; m_rdata = 7'd0;
    gq.delete(); rq.delete();
    rem0 = 0; rem1 = 0;
    req0 = 0; req1 = 0; lock0 = 0; lock1 = 0;
  endtask

  // One cycle: check what the last edge produced, advance engines, drive
  // the next request and push the expected grant for the coming edge.
  task automatic step();
    gexp_t g;
    rexp_t r;
    int    got;
    logic  win;
    logic [1:0] eng;
    @(negedge CLK);
    chk("gnt_mutex", 32'(gnt0 & gnt1), 0);
    chk("rvalid_mutex", 32'(rvalid0 & rvalid1), 0);
    got = gnt1 ? 1 : (gnt0 ? 0 : 2);
    if (rq.size() > 0) begin
      r = rq.pop_front();
      chk("rvalid0", 32'(rvalid0), 32'(r.eng == 2'd0));
      chk("rvalid1", 32'(rvalid1), 32'(r.eng == 2'd1));
      chk("rdata", 32'(rdata), 32'(r.d));
    end
    if (gq.size() > 0) begin
      g = gq.pop_front();
      dut_log.push_back(got);
      chk("gnt", got, 32'(g.eng));
      chk("busy", 32'(busy), 32'(g.eng != 2'd2));
      chk("W", 32'(W), 32'(g.w));
      chk("J", 32'(J), 32'(g.j));
      if (g.eng != 2'd2) m_rdata = cost_f(g.w, g.j);
      rq.push_back('{g.eng, m_rdata});
      if (g.eng == 2'd0) begin rem0--; a0 = a0 + 6'd1; lk0 = pick(mode0); end
      if (g.eng == 2'd1) begin rem1--; a1 = a1 + 6'd7; lk1 = pick(mode1); end
    end
    req0 = (rem0 > 0); lock0 = lk0; {w0, j0} = a0;
    req1 = (rem1 > 0); lock1 = lk1; {w1, j1} = a1;
    if (!req0 && !req1) begin
      eng = 2'd2;
      m_locked = 1'b0;
    end else begin
      if (req0 && req1) win = (m_locked && (m_burst < 4'(BM))) ? m_owner : ~m_owner;
      else win = req1;
      eng = {1'b0, win};
      m_locked = win ? lock1 : lock0;
      if (win == m_owner) m_burst = (m_burst == 4'd15) ? 4'd15 : m_burst + 4'd1;
      else begin m_burst = 4'd1; m_owner = win; end
      {m_w, m_j} = win ? a1 : a0;
    end
    gq.push_back('{eng, m_w, m_j});
  endtask

  task automatic phase(input int n0, input int md0, input int n1, input int md1, input int steps);
    if (rem0 <= 0) begin rem0 = 0; lk0 = pick(md0); end
    if (rem1 <= 0) begin rem1 = 0; lk1 = pick(md1); end
    mode0 = md0; mode1 = md1;
    rem0 += n0; rem1 += n1;
    repeat (steps) step();
  endtask

  task automatic do_reset();
    RST = 1'b1;
    model_reset();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_gnt", 32'({gnt1, gnt0}), 0);
    chk("rst_rvalid", 32'({rvalid1, rvalid0}), 0);
    chk("rst_rdata", 32'(rdata), 0);
    chk("rst_wj", 32'({W, J}), 0);
    chk("rst_busy", 32'(busy), 0);
`ifdef JAM_COST_ARB_STATS_EN
    chk("rst_stats", 32'(gcnt0 | gcnt1 | wcnt), 0);
`endif
    RST = 1'b0;
  endtask

  task automatic chk_log(input string tag, input int idx, input int exp);
    chk($sformatf("%s%0d", tag, idx), (idx < dut_log.size()) ? dut_log[idx] : 9, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 20; i++) exp_idle[i] = 0;
    exp_idle[20] = 1; exp_idle[21] = 0; exp_idle[22] = 0; exp_idle[23] = 2;
    lk0 = 0; lk1 = 0; mode0 = 0; mode1 = 0;
    w0 = 0; j0 = 0; w1 = 0; j1 = 0;

    // single engine, Cost(2,5)=37
    do_reset();
    a0 = {3'd2, 3'd5};
    phase(1, 0, 0, 0, 3);
    chk("single_rdata", 32'(rdata), 37);
    chk("single_rvalid0", 32'(rvalid0), 1);
    chk("single_rvalid1", 32'(rvalid1), 0);

    // contention without lock alternates 0,1,0,1
    do_reset();
    dut_log.delete();
    phase(2, 0, 2, 0, 5);
    for (int i = 0; i < 4; i++) chk_log("contend", i, i % 2);

    // locked burst: eight grants to engine 0, one to engine 1, then 0 resumes
    do_reset();
    dut_log.delete();
    phase(10, 1, 3, 0, 14);
    for (int i = 0; i < 13; i++) chk_log("lockseq", i, exp_lock[i]);

    // lock with idle peer: no gap, burst saturates so the late peer wins at once
    do_reset();
    dut_log.delete();
    phase(20, 1, 0, 0, 20);
    phase(2, 1, 1, 0, 5);
    for (int i = 0; i < 24; i++) chk_log("idlepeer", i, exp_idle[i]);

    // reset in the cycle gnt1 is high
    do_reset();
    phase(1, 0, 1, 0, 2);
    @(negedge CLK);
    chk("mid_gnt1_pre", 32'(gnt1), 1);
    #2 RST = 1'b1;
    #1;
    chk("mid_rst_gnt", 32'({gnt1, gnt0}), 0);
    chk("mid_rst_rvalid", 32'({rvalid1, rvalid0}), 0);
    chk("mid_rst_data", 32'({rdata, W, J, busy}), 0);
    model_reset();
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("mid_no_rvalid1", 32'(rvalid1), 0);
    chk("mid_rdata", 32'(rdata), 0);
    dut_log.delete();
    phase(1, 0, 1, 0, 3);
    chk_log("mid_first", 0, 0);
    chk_log("mid_first", 1, 1);

    // random traffic against the reference arbiter
    do_reset();
    for (int k = 0; k < 8; k++)
      phase($urandom_range(1, 12), $urandom_range(0, 2),
            $urandom_range(0, 12), $urandom_range(0, 2), 30);

`ifdef JAM_COST_ARB_STATS_EN
    do_reset();
    phase(4, 0, 4, 0, 6);
    rem0 = 0; rem1 = 0;
    phase(0, 0, 0, 0, 2);
    chk("stats_gcnt0", 32'(gcnt0), 3);
    chk("stats_gcnt1", 32'(gcnt1), 3);
    chk("stats_wcnt", 32'(wcnt), 6);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/jam_cost_arb.md
# jam_cost_arb

Two-port arbiter that shares the single job-assignment cost table (W/J address in, 7-bit Cost out) between two permutation-search engines. Each engine issues single-cycle read requests. The arbiter grants one read per cycle, drives the table address, and returns the cost one cycle later to the winning engine. Arbitration is round-robin with a bounded lock, so an engine can finish accumulating an 8-worker cost sum without interleaving.

## Interface
Parameters:
- BURST_MAX, 8, maximum consecutive locked grants to one requester while the other is waiting. Legal range 1..15.

Ports:
- CLK  in  1  clock. All state updates on the rising edge.
- RST  in  1  reset. Asynchronous, active-high.
- req0 / req1  in  1  read request from engine 0 / 1.
- lock0 / lock1  in  1  sampled with the request; asks to keep the grant for the next access.
- w0, j0 / w1, j1  in  3 each  worker/job address from engine 0 / 1.
- gnt0 / gnt1  out  1  registered; high for the cycle in which that engine's address is on W/J.
- rvalid0 / rvalid1  out  1  registered; high for the cycle in which rdata belongs to that engine.
- rdata  out  7  registered cost return, shared, qualified by rvalid0/rvalid1.
- W  out  3  cost table worker address, registered.
- J  out  3  cost table job address, registered.
- Cost  in  7  cost table data; combinationally valid for the current W/J.
- busy  out  1  registered; high when gnt0|gnt1 is high.

## Operation
- Internal state:
  - owner: last granted engine, 1 bit.
  - locked: lock bit captured with the last grant, 1 bit.
  - burst: consecutive grants to owner, 4 bits.
- Arbitration at each edge, using req/lock/address sampled at that edge:
  - No request: no grant. W/J hold their values. owner is unchanged. locked is cleared.
  - One request: that engine wins.
  - Both request, locked=1 and burst<BURST_MAX: owner wins again.
  - Both request, otherwise: the engine that is not owner wins (round-robin).
  - locked=1 but owner not requesting: the lock is dropped and normal rules apply.
- On a grant to engine x:
  - gnt_x<=1, other gnt<=0. W<=w_x, J<=j_x.
  - locked<=lock_x.
  - If x==owner, burst<=min(burst+1,15); otherwise burst<=1 and owner<=x.
- On a grant in the previous cycle to engine x: rdata<=Cost, rvalid_x<=1. Otherwise both rvalid<=0 and rdata holds.
- Lock limit: when burst reaches BURST_MAX with the other engine requesting, the lock is overridden for one arbitration and the grant rotates. If the other engine is idle, owner keeps winning and burst saturates at 15.
- gnt0 and gnt1 are never high together. rvalid0 and rvalid1 are never high together.
- Reset values: gnt0=gnt1=0, rvalid0=rvalid1=0, rdata=0, W=0, J=0, busy=0, owner=1 (engine 0 wins the first contention), locked=0, burst=0.
- Reset mid-operation: all state returns to reset values immediately. Any in-flight read is discarded and no rvalid is issued for it.

## Timing
- Read latency: request sampled at edge k; gnt and W/J valid after edge k; rdata/rvalid valid after edge k+1.
- Throughput: one read per cycle across both engines; back-to-back grants to the same engine are allowed.
- Handshake: an engine holds req and its address until it sees gnt_x high. It may present the next address in the cycle gnt_x is high.
- Lock boundary: lock sampled with the access numbered BURST_MAX does not extend ownership if the other engine is requesting.
- Simultaneous first requests after reset: engine 0 wins, engine 1 wins the next cycle (if unlocked).

## Configuration
- JAM_COST_ARB_STATS_EN defined:
  - Adds outputs gcnt0 and gcnt1 (16 bits each). Each increments on every grant to its engine and wraps at 65535→0.
  - Adds output wcnt (16 bits), incremented each cycle an engine requests and is not granted; wraps at 65535→0.
  - All three reset to 0.
- JAM_COST_ARB_STATS_EN undefined: these ports and counters do not exist. Arbitration behaviour is identical.

## Test plan
- Single engine: req0=1 with w0=2, j0=5 and table Cost(2,5)=37 → gnt0=1 with W=2, J=5 one cycle after the edge; rdata=37 with rvalid0=1 the following cycle; gnt1 and rvalid1 stay 0.
- Contention, no lock: req0=req1=1 held for 4 cycles → grants alternate 0,1,0,1. Each rvalid follows its gnt by exactly one cycle with the matching cost.
- Locked burst: both request, lock0=1 for 10 accesses, BURST_MAX=8 → eight consecutive gnt0, then one gnt1, then gnt0 resumes.
- Lock with idle peer: req1=0, lock0=1 for 20 accesses → gnt0 high every cycle, never a gap, burst saturates at 15.
- Reset mid-read: assert RST in the cycle gnt1=1 → all outputs 0 immediately; no rvalid1 after RST deasserts; the first contention afterwards grants engine 0.
- Stats (JAM_COST_ARB_STATS_EN): 6 cycles of req0=req1=1 without lock → gcnt0=3, gcnt1=3, wcnt=6.
